kgp_iter_addsub: RTL and testbench
==================================

Name: kgp_iter_addsub

Overview:
- Folded, multicycle counterpart to the team's combinational Kogge-Stone carry network for the 16-bit adder.
- Accepts two operands plus an add/subtract opcode over a valid/ready handshake.
- Encodes the operands into KGP (generate/propagate) vectors, then resolves carries with a single reused prefix-combine level, one level per cycle.
- Decodes the final carries into sum and flags, and holds the result until the consumer accepts it.
- Sits in the ALU datapath where area matters more than single-cycle latency.

Parameters:
WIDTH, 16, operand width; must be a power of two, at least 2
LEVELS, 4, prefix levels, equal to log2(WIDTH); combine distance at level L is 2^L

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand/opcode valid
in_ready  out  1  block can accept an operation
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_sub  in  1  0 selects A+B; 1 selects A-B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_sum  out  WIDTH  sum or difference
out_cout  out  1  carry out; for subtract, 1 means no borrow
out_ovf  out  1  two's-complement signed overflow
out_zero  out  1  out_sum equals 0

Behaviour:
- Position encoding (WIDTH+1 positions):
  - Position 0 is the carry-in, with g0 = in_sub and p0 = 0.
  - Position i+1 is operand bit i, using b' = in_b ^ {WIDTH{in_sub}}: g = a&b', p = a^b'.
- Combine rule at distance d, for position j ≥ d:
  - G[j] <= G[j] | (P[j] & G[j-d])
  - P[j] <= P[j] & P[j-d]
  - Positions j < d hold their values.
- States: IDLE, PFX, DONE. Level counter lvl is 0..LEVELS-1.
- IDLE:
  - in_ready = 1.
  - On the edge where in_valid & in_ready: register the encoded G/P, in_a[WIDTH-1], b'[WIDTH-1] and raw propagate bits; set lvl = 0; go to PFX.
- PFX:
  - in_ready = 0.
  - Each edge applies one combine at d = 2^lvl and increments lvl.
  - On the edge where lvl = LEVELS-1, use the combined values for that same edge to register:
    - out_sum[i] = p_raw[i+1] ^ G[i]
    - out_cout = g_raw[WIDTH] | (p_raw[WIDTH] & G[WIDTH-1])
    - out_ovf = carry into MSB ^ out_cout
    - out_zero
  - Then go to DONE.
- DONE:
  - out_valid = 1; all outputs stable.
  - On out_valid & out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle accept.
- Latency:
  - Accept at edge k gives out_valid high after edge k+LEVELS (4 for the default).
  - Minimum issue interval is LEVELS+2 cycles when out_ready is held high.
- in_valid while busy is ignored; the upstream must hold it. Operand inputs are sampled only on the accept edge.
- Reset, asynchronous and any state including mid-PFX:
  - State returns to IDLE.
  - out_valid = 0; out_sum = 0; out_cout, out_ovf, out_zero = 0; lvl = 0; the G/P registers clear.
  - in_ready is 1 once rst_n deasserts.
- Arithmetic is modulo 2^WIDTH. Subtract uses A + ~B + 1 exclusively.
- out_ready is ignored outside DONE.

Decomposition:
- Shared package holds:
  - The state encoding (IDLE, PFX, DONE).
  - The KGP position-0 constants: carry-in g = in_sub, p = 0.
  - The LEVELS derivation function.
- One sub-module: kgp_combine_level. It is a purely combinational, single prefix level over WIDTH+1 positions with a runtime distance select, instantiated once and reused every cycle.
- FSM, counter and sum decode live in the top.

Test Plan:
- add 0x1234 + 0x4321 -> out_sum 0x5555, cout 0, ovf 0, zero 0; out_valid rises exactly 4 cycles after accept.
- add 0xFFFF + 0x0001 -> out_sum 0x0000, cout 1, ovf 0, zero 1 (full-length carry ripple through all levels).
- sub 0x0005 - 0x0007 -> out_sum 0xFFFE, cout 0 (borrow); sub 0x0007 - 0x0005 -> 0x0002, cout 1.
- add 0x7FFF + 0x0001 -> 0x8000, ovf 1; sub 0x8000 - 0x0001 -> 0x7FFF, ovf 1, cout 1.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles in DONE -> outputs stable and in_ready = 0.
  - Pulse in_valid with new operands during PFX/DONE -> ignored; the next op is accepted only after the out handshake.
- Assert rst_n low at lvl = 2 -> immediate out_valid 0, out_sum 0, in_ready 1 after release; the following add 0x00FF + 0x0001 -> 0x0100.

Source files
------------

// File: rtl/kgp_iter_addsub_pkg.sv
// rtl/kgp_iter_addsub_pkg.sv - shared types and constants for the folded KGP adder/subtractor
package kgp_iter_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PFX  = 2'd1,
        ST_DONE = 2'd2
    } kgp_state_t;

    // Position 0 models the carry-in: it generates exactly when subtracting, never propagates.
    localparam logic KGP_POS0_P = 1'b0;

    function automatic logic kgp_pos0_g(input logic sub);
        return sub;
    endfunction

    function automatic int kgp_levels(input int width);
        int l;
        l = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << l) < width) begin
                l = l + 1;
            end
        end
        return l;
    endfunction

    function automatic int kgp_lvl_w(input int levels);
        return (levels > 1) ? $clog2(levels) : 1;
    endfunction

endpackage

// File: rtl/kgp_iter_addsub_combine.sv
// rtl/kgp_iter_addsub_combine.sv - one Kogge-Stone prefix level over WIDTH+1 positions, distance 2^lvl
module kgp_combine_level
    import kgp_iter_addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LEVELS = kgp_levels(WIDTH),
    parameter int LVL_W  = kgp_lvl_w(LEVELS)
) (
    input  logic [WIDTH:0]   i_g,
    input  logic [WIDTH:0]   i_p,
    input  logic [LVL_W-1:0] i_lvl,
    output logic [WIDTH:0]   o_g,
    output logic [WIDTH:0]   o_p
);

    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [LEVELS:0] w_dist;
    logic [WIDTH:0]  w_low_mask;

    assign w_dist     = {{LEVELS{1'b0}}, 1'b1} << i_lvl;
    assign w_low_mask = (ONE << w_dist) - ONE;

    // Shifting zeros into positions below the distance leaves those positions unchanged.
    assign o_g = i_g | (i_p & (i_g << w_dist));
    assign o_p = i_p & ((i_p << w_dist) | w_low_mask);

endmodule

// File: rtl/kgp_iter_addsub.sv
// rtl/kgp_iter_addsub.sv - folded multicycle KGP add/subtract, one prefix level per cycle
module kgp_iter_addsub
    import kgp_iter_addsub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LEVELS = kgp_levels(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int               LVL_W    = kgp_lvl_w(LEVELS);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVELS - 1);

    kgp_state_t       r_state;
    kgp_state_t       w_state_nxt;
    logic [WIDTH:0]   r_g;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_p_raw;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [LVL_W-1:0] r_lvl;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_inv;
    logic [WIDTH:0]   w_enc_g;
    logic [WIDTH:0]   w_enc_p;
    logic [WIDTH:0]   w_g_comb;
    logic [WIDTH:0]   w_p_comb;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    assign w_b_inv  = in_b ^ {WIDTH{in_sub}};
    assign w_enc_g  = {in_a & w_b_inv, kgp_pos0_g(in_sub)};
    assign w_enc_p  = {in_a ^ w_b_inv, KGP_POS0_P};
    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_state == ST_PFX) && (r_lvl == LVL_LAST);

    kgp_combine_level #(
        .WIDTH  (WIDTH),
        .LEVELS (LEVELS),
        .LVL_W  (LVL_W)
    ) u_combine (
        .i_g   (r_g),
        .i_p   (r_p),
        .i_lvl (r_lvl),
        .o_g   (w_g_comb),
        .o_p   (w_p_comb)
    );

    // After the final level, G[i] is the carry into operand bit i.
    assign w_sum  = r_p_raw ^ w_g_comb[WIDTH-1:0];
    assign w_cout = (r_a_msb & r_b_msb) | (r_p_raw[WIDTH-1] & w_g_comb[WIDTH-1]);
    assign w_ovf  = w_g_comb[WIDTH-1] ^ w_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_PFX;
            ST_PFX:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g     <= '0;
            r_p     <= '0;
            r_p_raw <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_lvl   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_accept) begin
            r_g     <= w_enc_g;
            r_p     <= w_enc_p;
            r_p_raw <= in_a ^ w_b_inv;
            r_a_msb <= in_a[WIDTH-1];
            r_b_msb <= w_b_inv[WIDTH-1];
            r_lvl   <= '0;
        end else if (r_state == ST_PFX) begin
            r_g   <= w_g_comb;
            r_p   <= w_p_comb;
            r_lvl <= r_lvl + LVL_W'(1);
            if (w_last) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
                r_zero <= (w_sum == '0);
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;
    assign out_zero  = r_zero;

endmodule

// File: tb/tb_kgp_iter_addsub.sv
// tb/tb_kgp_iter_addsub.sv - self-checking bench for kgp_iter_addsub
module tb_kgp_iter_addsub;

    localparam int LEVELS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;

    int n_cmp = 0;
    int n_err = 0;

    kgp_iter_addsub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation, optionally poking in_valid while busy, stall hold cycles in DONE.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input int hold, input bit poke);
        logic [16:0] full;
        logic [15:0] es;
        logic        ec;
        logic        eo;
        logic        ez;
        int          cnt;
        full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + 17'(sub);
        es   = full[15:0];
        ec   = full[16];
        if (sub) eo = (a[15] != b[15]) && (es[15] != a[15]);
        else     eo = (a[15] == b[15]) && (es[15] != a[15]);
        ez   = (es == 16'h0000);

        cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);

        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = poke;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_sub   = 1'($urandom_range(0, 1));
        check("in_ready_busy", 32'(in_ready), 32'd0);

        cnt = 0;
        while (!out_valid && cnt < 20) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cnt++;
        end
        out_ready = 1'b0;
        check("latency", 32'(cnt), 32'(LEVELS));
        check("sum",  32'(out_sum),  32'(es));
        check("cout", 32'(out_cout), 32'(ec));
        check("ovf",  32'(out_ovf),  32'(eo));
        check("zero", 32'(out_zero), 32'(ez));

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_stable", 32'({out_valid, in_ready, out_sum, out_cout, out_ovf, out_zero}),
                  32'({1'b1, 1'b0, es, ec, eo, ez}));
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("released", 32'({out_valid, in_ready}), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'({out_sum, out_cout, out_ovf, out_zero}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b1, 2, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
        run_op(16'hABCD, 16'h1357, 1'b0, 10, 1'b1);

        // Asynchronous reset while the prefix is at level 2.
        in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", 32'({out_sum, out_cout, out_ovf, out_zero}), 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
